mult_hilo_ctrl: RTL and testbench
=================================

# mult_hilo_ctrl

Sequencing stage around the 32x32 unsigned pipelined multiplier. It accepts MULT/MULTU requests from the CPU execute stage and drives operand magnitudes into the multiplier. It waits out the multiplier's fixed latency, applies sign correction to the 64-bit product, and commits the result into the architectural HI/LO registers with a busy/done handshake. It also services direct MTHI/MTLO writes.

## Interface
- MUL_LAT, 2: clock edges from the multiplier first sampling stable operands until its z output is valid.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- signed_op  in  1  1 = MULT (two's complement), 0 = MULTU.
- a, b  in  32 each  operands; sampled only on the accepting edge.
- mul_z  in  64  product from the unsigned multiplier.
- hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
- wdata  in  32  data for hi_we/lo_we.
- mul_a, mul_b  out  32 each  registered operand magnitudes to the multiplier; held stable for the whole operation.
- hi, lo  out  32 each  architectural HI/LO.
- busy  out  1  high from the cycle after acceptance until the capture edge.
- done  out  1  one-cycle pulse after HI/LO are updated by a multiply.

## Operation
- States: IDLE, WAIT. Counter cnt is sized to hold MUL_LAT.
- IDLE, start=1 at edge: accept the request.
  - mul_a <= (signed_op & a[31]) ? -a : a.
  - mul_b <= (signed_op & b[31]) ? -b : b.
  - neg <= signed_op & (a[31] ^ b[31]).
  - cnt <= MUL_LAT. Go to WAIT.
- Magnitude rule: 0x80000000 negates to 0x80000000 and is treated as unsigned 2^31. This is correct and needs no special case.
- WAIT, cnt != 0: cnt <= cnt - 1.
- WAIT, cnt == 0 (capture edge):
  - {hi, lo} <= neg ? (~mul_z + 1) : mul_z, computed mod 2^64.
  - Go to IDLE and set done <= 1.
- mul_z is ignored outside the capture edge.
- done is cleared on every edge where it is not being set.
- MTHI/MTLO:
  - In IDLE with start=0: hi_we writes hi <= wdata, and lo_we writes lo <= wdata. Both may be set in the same cycle.
  - While busy, writes are dropped.
  - In IDLE with start=1, writes are dropped; the multiply wins.
- start while busy is ignored; the controller holds no queue.
- mul_a/mul_b change only on an accepting edge.

## Timing
- Reset values: state=IDLE, cnt=0, neg=0, mul_a=0, mul_b=0, hi=0, lo=0, busy=0, done=0.
- Accepting edge E0. Capture edge is E(MUL_LAT+1); with default settings that is E3.
- busy is high in the cycles following E0 through E(MUL_LAT+1), i.e. MUL_LAT+1 cycles.
- done and the new hi/lo are visible in the cycle after the capture edge. busy is 0 in that cycle.
- A new start is accepted on the same edge where done is high (back-to-back). Throughput is one multiply per MUL_LAT+2 cycles.
- Reset asserted mid-operation: at that edge, all registers return to their reset values, the in-flight result is discarded, and no done pulse is produced.
- Reset has priority over start and the write strobes.

## Test plan
- MULTU, a=b=0xFFFFFFFF, start at E0:
  - busy high for 3 cycles.
  - hi=0xFFFFFFFE, lo=0x00000001 with done=1 after E3.
  - Bench multiplier is modelled with a 2-edge latency.
- MULT, a=0xFFFFFFFD (-3), b=5:
  - mul_a=3, mul_b=5.
  - Result hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
- MULT, a=b=0x80000000:
  - mul_a=mul_b=0x80000000.
  - Result hi=0x40000000, lo=0x00000000.
- MULT, a=7, b=0xFFFFFFFF (-1): result hi=0xFFFFFFFF, lo=0xFFFFFFF9.
- During busy: pulse start with a=1, b=1, and hi_we with wdata=0x1234.
  - Both are ignored; the original result is committed.
  - After done, hi_we with wdata=0x1234 sets hi=0x00001234 and leaves lo unchanged.
- Reset at E2 of an operation: at the next cycle all outputs are 0, no done pulse, and state is IDLE.
  - A subsequent MULTU 6*7 yields hi=0, lo=42.

Source files
------------

// File: rtl/mult_hilo_ctrl_if.sv
// CPU-side bundle of the HI/LO multiply controller: request, MTHI/MTLO writes,
// architectural HI/LO and the busy/done handshake.
interface mult_hilo_ctrl_if;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, signed_op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, signed_op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Sequences MULT/MULTU through an external unsigned pipelined multiplier,
// sign-corrects the product and commits it to HI/LO; also services MTHI/MTLO.
module mult_hilo_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mult_hilo_ctrl_if.slave   bus,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic [63:0]       mul_z
);
    localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          neg_reg, neg_next;
    logic [31:0]   mul_a_reg, mul_a_next;
    logic [31:0]   mul_b_reg, mul_b_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;
    logic          done_reg, done_next;

    logic [31:0]   opnd [2];
    logic [31:0]   mag  [2];
    logic [63:0]   prod_fix;

    assign opnd[0] = bus.a;
    assign opnd[1] = bus.b;

    // 0x80000000 maps onto itself, which is exactly unsigned 2^31.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            assign mag[gi] = (bus.signed_op & opnd[gi][31]) ? (32'd0 - opnd[gi]) : opnd[gi];
        end
    endgenerate

    assign prod_fix = neg_reg ? (~mul_z + 64'd1) : mul_z;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        neg_next   = neg_reg;
        mul_a_next = mul_a_reg;
        mul_b_next = mul_b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mul_a_next = mag[0];
                    mul_b_next = mag[1];
                    neg_next   = bus.signed_op & (bus.a[31] ^ bus.b[31]);
                    cnt_next   = CW'(MUL_LAT);
                    state_next = WAIT;
                end else begin
                    if (bus.hi_we) hi_next = bus.wdata;
                    if (bus.lo_we) lo_next = bus.wdata;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    {hi_next, lo_next} = prod_fix;
                    done_next          = 1'b1;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            neg_reg   <= 1'b0;
            mul_a_reg <= '0;
            mul_b_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            neg_reg   <= neg_next;
            mul_a_reg <= mul_a_next;
            mul_b_reg <= mul_b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    assign mul_a    = mul_a_reg;
    assign mul_b    = mul_b_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
    assign bus.busy = (state_reg == WAIT);
    assign bus.done = done_reg;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed plus randomized checks of mult_hilo_ctrl against a signed/unsigned
// arithmetic reference and a 2-edge multiplier model.
module tb_mult_hilo_ctrl;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_z;
    logic [63:0] z1, z2;

    int tests = 0;
    int fails = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mult_hilo_ctrl_if bus_if ();

    mult_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_z (mul_z)
    );

    always #5 clk = ~clk;

    // Unsigned multiplier: z valid two edges after stable operands are sampled.
    always_ff @(posedge clk) begin
        z1 <= 64'(mul_a) * 64'(mul_b);
        z2 <= z1;
    end
    assign mul_z = z2;

    function automatic logic [63:0] ref_prod(input bit s, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            return 64'(sa * sb);
        end
        return 64'(av) * 64'(bv);
    endfunction

    function automatic logic [31:0] ref_mag(input bit s, input logic [31:0] v);
        longint sv;
        if (!s) return v;
        sv = longint'($signed(v));
        return 32'((sv < 0) ? -sv : sv);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.start     = 1'b0;
        bus_if.signed_op = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.hi_we     = 1'b0;
        bus_if.lo_we     = 1'b0;
        bus_if.wdata     = '0;
    endtask

    // Call while the controller is idle (or in its done cycle), #1 after an edge.
    task automatic do_mult(input bit s, input logic [31:0] av, input logic [31:0] bv, input bit disturb);
        logic [63:0] exp;
        int bc, n;
        exp = ref_prod(s, av, bv);
        bus_if.start     = 1'b1;
        bus_if.signed_op = s;
        bus_if.a         = av;
        bus_if.b         = bv;
        bus_if.hi_we     = 1'($urandom_range(0, 1));
        bus_if.lo_we     = 1'($urandom_range(0, 1));
        bus_if.wdata     = $urandom;
        @(posedge clk); #1;
        idle_inputs();
        bus_if.a         = $urandom;
        bus_if.b         = $urandom;
        bus_if.signed_op = 1'($urandom_range(0, 1));
        chk("accept_busy", 64'(bus_if.busy), 64'd1);
        chk("done_clear", 64'(bus_if.done), 64'd0);
        chk("mul_a", 64'(mul_a), 64'(ref_mag(s, av)));
        chk("mul_b", 64'(mul_b), 64'(ref_mag(s, bv)));
        bc = 0;
        n  = 0;
        while (!bus_if.done && n < 20) begin
            if (bus_if.busy) bc++;
            chk("hi_hold", 64'(bus_if.hi), 64'(hi_m));
            chk("lo_hold", 64'(bus_if.lo), 64'(lo_m));
            chk("mul_a_stable", 64'(mul_a), 64'(ref_mag(s, av)));
            if (disturb && n == 0) begin
                bus_if.start = 1'b1;
                bus_if.a     = 32'd1;
                bus_if.b     = 32'd1;
                bus_if.hi_we = 1'b1;
                bus_if.wdata = 32'h1234;
            end
            @(posedge clk); #1;
            bus_if.start = 1'b0;
            bus_if.hi_we = 1'b0;
            n++;
        end
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        chk("done", 64'(bus_if.done), 64'd1);
        chk("busy_after", 64'(bus_if.busy), 64'd0);
        chk("busy_cycles", 64'(bc), 64'(MUL_LAT + 1));
        chk("hi", 64'(bus_if.hi), 64'(hi_m));
        chk("lo", 64'(bus_if.lo), 64'(lo_m));
        $display("[TB] mult s=%0d a=%h b=%h -> hi=%h lo=%h", s, av, bv, bus_if.hi, bus_if.lo);
    endtask

    task automatic mtx(input bit hw, input bit lw, input logic [31:0] d);
        bus_if.hi_we = hw;
        bus_if.lo_we = lw;
        bus_if.wdata = d;
        @(posedge clk); #1;
        idle_inputs();
        if (hw) hi_m = d;
        if (lw) lo_m = d;
        chk("mt_hi", 64'(bus_if.hi), 64'(hi_m));
        chk("mt_lo", 64'(bus_if.lo), 64'(lo_m));
        chk("mt_nodone", 64'(bus_if.done), 64'd0);
        $display("[TB] write hi_we=%0d lo_we=%0d d=%h -> hi=%h lo=%h", hw, lw, d, bus_if.hi, bus_if.lo);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hi"}, 64'(bus_if.hi), 64'd0);
        chk({tag, "_lo"}, 64'(bus_if.lo), 64'd0);
        chk({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus_if.done), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        $display("[TB] reset state checked");
        reset = 1'b0;
        @(posedge clk); #1;

        do_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_max_hi", 64'(bus_if.hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_max_lo", 64'(bus_if.lo), 64'h0000_0000_0000_0001);
        do_mult(1'b1, 32'hFFFFFFFD, 32'd5, 1'b0);
        chk("mult_m3x5_lo", 64'(bus_if.lo), 64'h0000_0000_FFFF_FFF1);
        do_mult(1'b1, 32'h80000000, 32'h80000000, 1'b0);
        chk("mult_min_hi", 64'(bus_if.hi), 64'h0000_0000_4000_0000);
        do_mult(1'b1, 32'd7, 32'hFFFFFFFF, 1'b0);
        chk("mult_7xm1_lo", 64'(bus_if.lo), 64'h0000_0000_FFFF_FFF9);

        do_mult(1'b0, 32'h0001_0003, 32'h0000_0100, 1'b1);
        mtx(1'b1, 1'b0, 32'h0000_1234);
        chk("mthi_1234", 64'(bus_if.hi), 64'h0000_0000_0000_1234);
        mtx(1'b1, 1'b1, 32'hCAFE_F00D);
        mtx(1'b0, 1'b1, 32'h0BAD_BEEF);

        // Reset sampled on E2 of an operation.
        bus_if.start     = 1'b1;
        bus_if.signed_op = 1'b1;
        bus_if.a         = 32'h8765_4321;
        bus_if.b         = 32'h1357_9BDF;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        chk_all_zero("midreset");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midreset_nodone", 64'(bus_if.done), 64'd0);
            chk("midreset_idle", 64'(bus_if.busy), 64'd0);
        end
        $display("[TB] mid-operation reset checked");
        do_mult(1'b0, 32'd6, 32'd7, 1'b0);
        chk("multu_6x7_lo", 64'(bus_if.lo), 64'd42);
        chk("multu_6x7_hi", 64'(bus_if.hi), 64'd0);

        // Back-to-back randomized operations, with occasional writes in between.
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 1) ra = 32'h8000_0000;
            if (i % 6 == 3) rb = 32'hFFFF_FFFF;
            if (i % 6 == 5) ra = 32'd0;
            do_mult(rs, ra, rb, 1'($urandom_range(0, 1)));
            if (i % 4 == 3) mtx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
